// File: rtl/fft_chan_sched.sv
// Round-robin frame scheduler that shares one FFT core between NCH channels:
// streams a granted channel's frame into the FFT and forwards tagged output bins.
module fft_chan_sched #(
   parameter int NCH  = 4,
   parameter int CHW  = 2,
   parameter int N    = 256,
   parameter int LOGN = 8,
   parameter int DW   = 16,
   parameter int TMO  = 2047
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NCH-1:0]  frm_req,
   output logic [NCH-1:0]  frm_ack,
   output logic            rd_en,
   output logic [CHW-1:0]  rd_ch,
   output logic [LOGN-1:0] rd_addr,
   input  logic [DW-1:0]   rd_data,
   output logic [DW-1:0]   fft_x_re,
   output logic            fft_x_valid,
   input  logic [DW-1:0]   fft_y_re,
   input  logic [DW-1:0]   fft_y_im,
   input  logic            fft_y_valid,
   input  logic            fft_y_last,
   output logic [DW-1:0]   bin_re,
   output logic [DW-1:0]   bin_im,
   output logic [LOGN-1:0] bin_idx,
   output logic [CHW-1:0]  bin_ch,
   output logic            bin_valid,
   output logic            bin_last,
   output logic            sweep_done,
   output logic            err_tmo,
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam int          RCW    = LOGN + 1;
   localparam int unsigned NCH_U  = NCH;
   localparam logic [RCW-1:0] RD_END = RCW'(N);
   localparam logic [11:0]    WD_END = 12'(TMO);
   localparam logic [NCH-1:0] ALL_DONE = '1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CHW-1:0]  r_cur_ch;
   logic [CHW-1:0]  r_ptr;
   logic [CHW-1:0]  w_grant_ch;
   logic [CHW-1:0]  w_cand;
   logic            w_grant_vld;
   logic [RCW-1:0]  r_rd_cnt;
   logic            r_x_valid;
   logic [11:0]     r_wd_cnt;
   logic [LOGN-1:0] r_idx_cnt;
   logic [NCH-1:0]  r_done_mask;
   logic [NCH-1:0]  w_done_nxt;
   logic [NCH-1:0]  w_ch_onehot;
   logic            w_load_end;
   logic            w_y_take;
   logic            w_y_end;
   logic            w_wd_exp;
   logic            r_bin_valid;
   logic            r_bin_last;
   logic            r_sweep;
   logic [DW-1:0]   r_bin_re;
   logic [DW-1:0]   r_bin_im;
   logic [LOGN-1:0] r_bin_idx;
   logic [CHW-1:0]  r_bin_ch;

   // First requester strictly after the last grant, wrapping at NCH.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_ch  = '0;
      w_cand      = '0;
      for (int unsigned i = 1; i <= NCH_U; i++) begin
         w_cand = CHW'((32'(r_ptr) + i) % NCH_U);
         if (!w_grant_vld && frm_req[w_cand]) begin
            w_grant_vld = 1'b1;
            w_grant_ch  = w_cand;
         end
      end
   end

   assign w_ch_onehot = {{(NCH-1){1'b0}}, 1'b1} << r_cur_ch;
   assign w_done_nxt  = r_done_mask | w_ch_onehot;
   assign w_load_end  = (r_state == S_LOAD) && (r_rd_cnt == RD_END);
   assign w_y_take    = (r_state == S_WAIT) && fft_y_valid;
   assign w_y_end     = w_y_take && fft_y_last;
   assign w_wd_exp    = (r_state == S_WAIT) && (r_wd_cnt == WD_END) && !w_y_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_grant_vld) w_state_nxt = S_LOAD;
         S_LOAD:  if (w_load_end) w_state_nxt = S_WAIT;
         S_WAIT:  if (w_y_end || w_wd_exp) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // LOAD spans N read cycles plus the cycle that presents the last sample.
   always_comb begin
      rd_en   = 1'b0;
      frm_ack = '0;
      err_tmo = 1'b0;
      busy    = 1'b0;
      unique case (r_state)
         S_IDLE: busy = 1'b0;
         S_LOAD: begin
            busy  = 1'b1;
            rd_en = !r_rd_cnt[LOGN];
            if (w_load_end) frm_ack = w_ch_onehot;
         end
         S_WAIT: begin
            busy    = 1'b1;
            err_tmo = w_wd_exp;
         end
         default: busy = 1'b0;
      endcase
   end

   assign rd_ch       = rd_en ? r_cur_ch : '0;
   assign rd_addr     = rd_en ? r_rd_cnt[LOGN-1:0] : '0;
   assign fft_x_valid = r_x_valid;
   assign fft_x_re    = r_x_valid ? rd_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_ch  <= '0;
         r_ptr     <= CHW'(NCH - 1);
         r_rd_cnt  <= '0;
         r_x_valid <= 1'b0;
         r_wd_cnt  <= '0;
         r_idx_cnt <= '0;
      end else begin
         r_x_valid <= rd_en;
         unique case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_cur_ch  <= w_grant_ch;
                  r_ptr     <= w_grant_ch;
                  r_rd_cnt  <= '0;
                  r_idx_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (w_load_end) r_wd_cnt <= '0;
               else            r_rd_cnt <= r_rd_cnt + RCW'(1);
            end
            S_WAIT: begin
               r_wd_cnt <= r_wd_cnt + 12'(1);
               if (fft_y_valid) r_idx_cnt <= r_idx_cnt + LOGN'(1);
            end
            default: r_rd_cnt <= '0;
         endcase
      end
   end

   // Bins are re-timed one cycle; sweep_done lands with the completing bin_last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin_valid <= 1'b0;
         r_bin_last  <= 1'b0;
         r_sweep     <= 1'b0;
         r_bin_re    <= '0;
         r_bin_im    <= '0;
         r_bin_idx   <= '0;
         r_bin_ch    <= '0;
         r_done_mask <= '0;
      end else begin
         r_bin_valid <= w_y_take;
         r_bin_last  <= w_y_end;
         r_sweep     <= w_y_end && (w_done_nxt == ALL_DONE);
         if (w_y_take) begin
            r_bin_re  <= fft_y_re;
            r_bin_im  <= fft_y_im;
            r_bin_idx <= r_idx_cnt;
            r_bin_ch  <= r_cur_ch;
         end
         if (w_y_end) r_done_mask <= (w_done_nxt == ALL_DONE) ? '0 : w_done_nxt;
      end
   end

   assign bin_valid  = r_bin_valid;
   assign bin_last   = r_bin_last;
   assign bin_re     = r_bin_re;
   assign bin_im     = r_bin_im;
   assign bin_idx    = r_bin_idx;
   assign bin_ch     = r_bin_ch;
   assign sweep_done = r_sweep;

endmodule

// File: tb/tb_fft_chan_sched.sv
// Directed/randomized bench for fft_chan_sched with a frame-level reference
// model of arbitration, sample buffer, FFT output stream and sweep tracking.
module tb_fft_chan_sched;
   localparam int NCH  = 4;
   localparam int CHW  = 2;
   localparam int N    = 256;
   localparam int LOGN = 8;
   localparam int DW   = 16;
   localparam int TMO  = 2047;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NCH-1:0]  frm_req;
   logic [NCH-1:0]  frm_ack;
   logic            rd_en;
   logic [CHW-1:0]  rd_ch;
   logic [LOGN-1:0] rd_addr;
   logic [DW-1:0]   rd_data;
   logic [DW-1:0]   fft_x_re;
   logic            fft_x_valid;
   logic [DW-1:0]   fft_y_re;
   logic [DW-1:0]   fft_y_im;
   logic            fft_y_valid;
   logic            fft_y_last;
   logic [DW-1:0]   bin_re;
   logic [DW-1:0]   bin_im;
   logic [LOGN-1:0] bin_idx;
   logic [CHW-1:0]  bin_ch;
   logic            bin_valid;
   logic            bin_last;
   logic            sweep_done;
   logic            err_tmo;
   logic            busy;

   always #5 clk = ~clk;

   fft_chan_sched #(
      .NCH(NCH), .CHW(CHW), .N(N), .LOGN(LOGN), .DW(DW), .TMO(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .frm_req(frm_req), .frm_ack(frm_ack),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
      .fft_x_re(fft_x_re), .fft_x_valid(fft_x_valid),
      .fft_y_re(fft_y_re), .fft_y_im(fft_y_im),
      .fft_y_valid(fft_y_valid), .fft_y_last(fft_y_last),
      .bin_re(bin_re), .bin_im(bin_im), .bin_idx(bin_idx), .bin_ch(bin_ch),
      .bin_valid(bin_valid), .bin_last(bin_last),
      .sweep_done(sweep_done), .err_tmo(err_tmo), .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   logic [DW-1:0]   mem [NCH][N];
   int              ptr_m;
   logic [NCH-1:0]  mask_m;
   logic            p_rd_en;
   logic [CHW-1:0]  p_ch;
   logic [LOGN-1:0] p_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; the sample buffer answers the previous cycle's read.
   task automatic cyc();
      @(posedge clk);
      #1;
      rd_data = p_rd_en ? mem[p_ch][p_addr] : DW'($urandom);
      #1;
      p_rd_en = rd_en;
      p_ch    = rd_ch;
      p_addr  = rd_addr;
   endtask

   task automatic spur();
      fft_y_valid = 1'($urandom);
      fft_y_last  = 1'($urandom);
      fft_y_re    = DW'($urandom);
      fft_y_im    = DW'($urandom);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".frm_ack"}, frm_ack, 0);
      chk({tag, ".rd_en"}, rd_en, 0);
      chk({tag, ".rd_ch"}, rd_ch, 0);
      chk({tag, ".rd_addr"}, rd_addr, 0);
      chk({tag, ".x_re"}, fft_x_re, 0);
      chk({tag, ".x_valid"}, fft_x_valid, 0);
      chk({tag, ".bin_re"}, bin_re, 0);
      chk({tag, ".bin_im"}, bin_im, 0);
      chk({tag, ".bin_idx"}, bin_idx, 0);
      chk({tag, ".bin_ch"}, bin_ch, 0);
      chk({tag, ".bin_valid"}, bin_valid, 0);
      chk({tag, ".bin_last"}, bin_last, 0);
      chk({tag, ".sweep"}, sweep_done, 0);
      chk({tag, ".err_tmo"}, err_tmo, 0);
      chk({tag, ".busy"}, busy, 0);
   endtask

   function automatic int pick(input logic [NCH-1:0] req, input int p);
      for (int i = 1; i <= NCH; i++)
         if (req[(p + i) % NCH]) return (p + i) % NCH;
      return -1;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         spur();
         cyc();
         chk("idle.busy", busy, 0);
         chk("idle.bin_valid", bin_valid, 0);
         chk("idle.rd_en", rd_en, 0);
      end
   endtask

   // Entered in the IDLE cycle that sees frm_req; returns in the next IDLE cycle.
   task automatic do_frame(input bit tmo, input bit rereq);
      int ch, b, gap, nb, pidx;
      bit pv, pl, sw;
      logic [DW-1:0]  pre, pim;
      logic [NCH-1:0] nm;
      ch = pick(frm_req, ptr_m);
      if (ch < 0) begin
         $display("FAIL frame.setup: observed no request expected a pending request");
         $fatal(1, "bench sequencing error");
      end
      ptr_m = ch;
      nm = mask_m | (NCH'(1) << ch);
      sw = !tmo && (nm == '1);
      if (!tmo) mask_m = sw ? '0 : nm;
      spur();
      for (int k = 0; k < N; k++) begin
         cyc();
         chk("load.rd_en", rd_en, 1);
         chk("load.rd_ch", rd_ch, ch);
         chk("load.rd_addr", rd_addr, k);
         chk("load.x_valid", fft_x_valid, k > 0);
         if (k > 0) chk("load.x_re", fft_x_re, mem[ch][k-1]);
         chk("load.frm_ack", frm_ack, 0);
         chk("load.bin_valid", bin_valid, 0);
         chk("load.busy", busy, 1);
         spur();
      end
      cyc();
      chk("ack.rd_en", rd_en, 0);
      chk("ack.x_valid", fft_x_valid, 1);
      chk("ack.x_re", fft_x_re, mem[ch][N-1]);
      chk("ack.frm_ack", frm_ack, NCH'(1) << ch);
      chk("ack.bin_valid", bin_valid, 0);
      chk("ack.busy", busy, 1);
      spur();
      pv = 0; pl = 0; b = 0; pidx = 0; pre = '0; pim = '0;
      nb  = tmo ? $urandom_range(1, 20) : N;
      gap = $urandom_range(0, 5);
      for (int w = 0; w <= TMO + 1; w++) begin
         cyc();
         if (w == 0) frm_req[ch] = rereq;
         chk("bin.valid", bin_valid, pv);
         if (pv) begin
            chk("bin.idx", bin_idx, pidx);
            chk("bin.ch", bin_ch, ch);
            chk("bin.re", bin_re, pre);
            chk("bin.im", bin_im, pim);
            chk("bin.last", bin_last, pl);
         end
         chk("bin.sweep", sweep_done, pv && pl && sw);
         chk("wait.frm_ack", frm_ack, 0);
         if ((pv && pl) || w == TMO + 1) begin
            chk("end.busy", busy, 0);
            chk("end.err_tmo", err_tmo, 0);
            break;
         end
         chk("wait.busy", busy, 1);
         chk("wait.err_tmo", err_tmo, tmo && w == TMO);
         pv = 0; pl = 0;
         if (gap > 0) gap--;
         else if (b < nb && w < TMO) begin
            pv   = 1;
            pidx = b;
            pre  = DW'($urandom);
            pim  = DW'($urandom);
            pl   = !tmo && (b == N - 1);
            b++;
            gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         end
         fft_y_valid = pv;
         fft_y_last  = pv ? pl : 1'($urandom);
         fft_y_re    = pre;
         fft_y_im    = pim;
      end
      spur();
   endtask

   initial begin
      int guard;
      frm_req = '0; rd_data = '0;
      fft_y_valid = 1'b0; fft_y_last = 1'b0; fft_y_re = '0; fft_y_im = '0;
      p_rd_en = 1'b0; p_ch = '0; p_addr = '0;
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < N; i++) mem[c][i] = DW'($urandom);
      for (int i = 0; i < N; i++) mem[0][i] = DW'(i);
      ptr_m = NCH - 1; mask_m = '0;

      #2 chk_zero("reset");
      spur();
      cyc(); cyc();
      chk_zero("reset.hold");
      rst_n = 1'b1;
      idle(3);

      // Single channel, ramp data, no sweep.
      frm_req = 4'b0001;
      do_frame(0, 0);

      // Fairness: both keep re-requesting; order must alternate 1,2,1,2.
      frm_req = 4'b0110;
      do_frame(0, 1);
      do_frame(0, 1);
      do_frame(0, 0);
      do_frame(0, 0);
      idle(4);

      // Timeout on ch3 must not mark it done: ch0 then no sweep, ch3 then sweep.
      frm_req = 4'b1000;
      do_frame(1, 0);
      frm_req = 4'b0001;
      do_frame(0, 0);
      frm_req = 4'b1000;
      do_frame(0, 0);

      // All four at once: 0,1,2,3 with sweep on channel 3.
      frm_req = 4'b1111;
      for (int i = 0; i < NCH; i++) do_frame(0, 0);
      idle(2);

      // Randomized request patterns.
      for (int r = 0; r < 6; r++) begin
         frm_req = frm_req | NCH'($urandom_range(1, 15));
         do_frame(0, 1'($urandom));
      end
      frm_req = '0;
      idle(2);

      // Reset in the middle of a frame read.
      frm_req = 4'b0001;
      spur();
      guard = 0;
      do begin
         cyc();
         guard++;
      end while (!(rd_en === 1'b1 && rd_addr === LOGN'(100)) && guard < 400);
      chk("midrst.reach_addr", rd_addr, 100);
      rst_n = 1'b0;
      #1 chk_zero("midrst.async");
      p_rd_en = 1'b0;
      spur();
      cyc();
      chk_zero("midrst.hold1");
      spur();
      cyc();
      chk_zero("midrst.hold2");
      rst_n = 1'b1;
      ptr_m = NCH - 1; mask_m = '0;
      frm_req = 4'b0100;
      do_frame(0, 0);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
